// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - AXI-Lite response codes and request-master FSM states
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  // Anything other than OKAY is reported as an error to the requester.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_req_master.sv
// rtl/axi_lite_req_master.sv - single-outstanding request port to AXI-Lite master bridge
module axi_lite_req_master
  import axi_lite_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 10,
  parameter int AXI_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [AXI_DATA_WIDTH-1:0] req_wdata,

  output logic                      resp_valid,
  output logic [AXI_DATA_WIDTH-1:0] resp_rdata,
  output logic                      resp_err,

  output logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
  output logic                      axi_awvalid,
  input  logic                      axi_awready,

  output logic [AXI_DATA_WIDTH-1:0] axi_wdata,
  output logic                      axi_wstrb,
  output logic                      axi_wvalid,
  input  logic                      axi_wready,

  input  logic [1:0]                axi_bresp,
  input  logic                      axi_bvalid,
  output logic                      axi_bready,

  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,

  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]                axi_rresp,
  input  logic                      axi_rvalid,
  output logic                      axi_rready
);

  state_t                    state;
  state_t                    state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic                      aw_done;
  logic                      w_done;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic [AXI_DATA_WIDTH-1:0] rdata_q;

  logic req_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;

  assign axi_awaddr = addr_q;
  assign axi_araddr = addr_q;
  assign axi_wdata  = wdata_q;
  assign axi_wstrb  = 1'b1;

  // Outputs are masked by reset so nothing is offered even in the cycle reset rises.
  assign resp_valid = resp_valid_q & ~reset;
  assign resp_err   = resp_err_q & ~reset;
  assign resp_rdata = reset ? '0 : rdata_q;

  assign req_hs = req_valid & req_ready;
  assign aw_hs  = axi_awvalid & axi_awready;
  assign w_hs   = axi_wvalid & axi_wready;
  assign b_hs   = axi_bvalid & axi_bready;
  assign r_hs   = axi_rvalid & axi_rready;

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_bready  = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            state_nxt = req_we ? WR : RD_ADDR;
          end
        end
        WR: begin
          axi_awvalid = ~aw_done;
          axi_wvalid  = ~w_done;
          // aw and w may complete in either order; leave once both have.
          if ((aw_done | (~aw_done & axi_awready)) && (w_done | (~w_done & axi_wready))) begin
            state_nxt = WR_RESP;
          end
        end
        WR_RESP: begin
          axi_bready = 1'b1;
          if (axi_bvalid) begin
            state_nxt = IDLE;
          end
        end
        RD_ADDR: begin
          axi_arvalid = 1'b1;
          if (axi_arready) begin
            state_nxt = RD_DATA;
          end
        end
        RD_DATA: begin
          axi_rready = 1'b1;
          if (axi_rvalid) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state        <= state_nxt;
      resp_valid_q <= 1'b0;
      if (req_hs) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if (b_hs) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= resp_is_err(axi_bresp);
      end
      // Read data is only replaced by a completed read; writes leave it alone.
      if (r_hs) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= resp_is_err(axi_rresp);
        rdata_q      <= axi_rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_req_master.sv
// tb/tb_axi_lite_req_master.sv - randomized self-checking bench for axi_lite_req_master
module tb_axi_lite_req_master;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] axi_awaddr;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [DW-1:0] axi_wdata;
  logic          axi_wstrb;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [AW-1:0] axi_araddr;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [DW-1:0] axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rvalid;
  logic          axi_rready;

  always #5 clk = ~clk;

  axi_lite_req_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  int vectors = 0;
  int miscompares = 0;

  // slave behaviour knobs
  int         cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0, cfg_r_dly = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  bit         cfg_rdata_ovr = 0;
  logic [7:0] cfg_rdata = 8'h00;
  bit         cfg_spurious = 0;

  // slave observations
  int            n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
  logic [AW-1:0] last_awaddr, last_araddr;
  logic [DW-1:0] last_wdata;
  logic          last_wstrb;
  logic [DW-1:0] slv_mem [0:1023];

  // reference model
  logic [DW-1:0] exp_mem [0:1023];
  logic [DW-1:0] model_rdata = '0;

  // Slave: every decision is made on the falling edge, handshakes land on the next rising edge.
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    bit got_aw, got_w, pend_b, pend_r;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0; wa = '0; ra = '0; wd = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    axi_arready = 0; axi_rvalid = 0; axi_rresp = 0; axi_rdata = 0;
    forever begin
      @(negedge clk);
      axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0; axi_rvalid = 0;
      if (reset) begin
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        got_aw = 0; got_w = 0; pend_b = 0; pend_r = 0;
        continue;
      end
      if (pend_b) begin
        if (b_c >= cfg_b_dly) begin
          axi_bvalid = 1; axi_bresp = cfg_bresp;
          if (axi_bready) begin n_b++; pend_b = 0; b_c = 0; end
        end else b_c++;
      end else if (cfg_spurious) begin
        axi_bvalid = 1; axi_bresp = 2'b11;
      end
      if (pend_r) begin
        if (r_c >= cfg_r_dly) begin
          axi_rvalid = 1; axi_rresp = cfg_rresp;
          axi_rdata = cfg_rdata_ovr ? cfg_rdata : slv_mem[ra];
          if (axi_rready) begin n_r++; pend_r = 0; r_c = 0; end
        end else r_c++;
      end else if (cfg_spurious) begin
        axi_rvalid = 1; axi_rresp = 2'b11; axi_rdata = 8'hEE;
      end
      if (axi_awvalid) begin
        if (aw_c >= cfg_aw_dly) begin
          axi_awready = 1; n_aw++; wa = axi_awaddr; last_awaddr = axi_awaddr; got_aw = 1; aw_c = 0;
        end else aw_c++;
      end
      if (axi_wvalid) begin
        if (w_c >= cfg_w_dly) begin
          axi_wready = 1; n_w++; wd = axi_wdata; last_wdata = axi_wdata; last_wstrb = axi_wstrb;
          got_w = 1; w_c = 0;
        end else w_c++;
      end
      if (got_aw && got_w) begin
        slv_mem[wa] = wd; pend_b = 1; b_c = 0; got_aw = 0; got_w = 0;
      end
      if (axi_arvalid) begin
        if (ar_c >= cfg_ar_dly) begin
          axi_arready = 1; n_ar++; ra = axi_araddr; last_araddr = axi_araddr; pend_r = 1; r_c = 0; ar_c = 0;
        end else ar_c++;
      end
    end
  end

  // Issues one request at the current falling edge and returns at the falling edge where resp_valid is seen.
  task automatic do_txn(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int d1, input int d2, input int d3, input logic [1:0] resp,
                        input bit ovr, input logic [DW-1:0] ovr_d, input string name);
    int lat, exp_lat, guard, busy_viol;
    int aw0, w0, b0, ar0, r0;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    if (we) begin
      cfg_aw_dly = d1; cfg_w_dly = d2; cfg_b_dly = d3; cfg_bresp = resp;
      exp_mem[a] = d;
      exp_lat = 3 + ((d1 > d2) ? d1 : d2) + d3;
    end else begin
      cfg_ar_dly = d1; cfg_r_dly = d3; cfg_rresp = resp; cfg_rdata_ovr = ovr; cfg_rdata = ovr_d;
      model_rdata = ovr ? ovr_d : exp_mem[a];
      exp_lat = 3 + d1 + d3;
    end
    exp_rd = model_rdata;
    exp_err = (resp != 2'b00);
    aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar; r0 = n_r;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept: req_ready=%b required 1", name, req_ready);
    end
    @(negedge clk);
    req_valid = 0;
    lat = 1; busy_viol = 0;
    while (resp_valid !== 1'b1 && lat < 200) begin
      if (req_ready !== 1'b0) busy_viol++;
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, exp_lat);
    end
    vectors++;
    if (busy_viol != 0) begin
      miscompares++;
      $display("FAIL %s busy_ready: req_ready high in %0d busy cycles required 0", name, busy_viol);
    end
    vectors++;
    if (resp_err !== exp_err) begin
      miscompares++;
      $display("FAIL %s resp_err: got %b required %b", name, resp_err, exp_err);
    end
    vectors++;
    if (resp_rdata !== exp_rd) begin
      miscompares++;
      $display("FAIL %s resp_rdata: got %h required %h", name, resp_rdata, exp_rd);
    end
    vectors++;
    if (n_aw != aw0 + int'(we) || n_w != w0 + int'(we) || n_b != b0 + int'(we) ||
        n_ar != ar0 + int'(!we) || n_r != r0 + int'(!we)) begin
      miscompares++;
      $display("FAIL %s handshakes: aw/w/b/ar/r=%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d", name,
               n_aw - aw0, n_w - w0, n_b - b0, n_ar - ar0, n_r - r0,
               int'(we), int'(we), int'(we), int'(!we), int'(!we));
    end
    vectors++;
    if (we) begin
      if (last_awaddr !== a || last_wdata !== d || last_wstrb !== 1'b1) begin
        miscompares++;
        $display("FAIL %s write_beat: addr=%h data=%h strb=%b required %h %h 1", name,
                 last_awaddr, last_wdata, last_wstrb, a, d);
      end
    end else begin
      if (last_araddr !== a) begin
        miscompares++;
        $display("FAIL %s read_addr: got %h required %h", name, last_araddr, a);
      end
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_at_resp: req_ready=%b required 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({req_ready, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid, resp_err} !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 00000000",
               {req_ready, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid, resp_err});
    end
    vectors++;
    if (resp_rdata !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h required 00", resp_rdata);
    end
    reset = 0;
    model_rdata = '0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 1", req_ready);
    end
  endtask

  task automatic test_write_read();
    do_txn(1, 10'h0B0, 8'h10, 0, 0, 0, 2'b00, 0, 8'h00, "wr_0b0");
    @(negedge clk);
    vectors++;
    if (resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL resp_pulse_width: resp_valid=%b required 0", resp_valid);
    end
    do_txn(0, 10'h0B0, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00, "rd_0b0");
    @(negedge clk);
  endtask

  task automatic test_split_write();
    do_txn(1, 10'h0C0, 8'h6C, 3, 0, 0, 2'b00, 0, 8'h00, "split_w_first");
    @(negedge clk);
    do_txn(1, 10'h0C1, 8'h93, 0, 2, 1, 2'b00, 0, 8'h00, "split_aw_first");
    @(negedge clk);
  endtask

  task automatic test_b_stall();
    do_txn(1, 10'h0C2, 8'h77, 0, 0, 10, 2'b00, 0, 8'h00, "b_stall");
    @(negedge clk);
  endtask

  task automatic test_read_err();
    do_txn(0, 10'h0C4, 8'h00, 0, 0, 0, axi_lite_pkg::RESP_SLVERR, 1, 8'hA5, "rd_slverr");
    cfg_rdata_ovr = 0;
    @(negedge clk);
    do_txn(1, 10'h0C8, 8'h5A, 0, 0, 0, axi_lite_pkg::RESP_SLVERR, 0, 8'h00, "wr_slverr");
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      do_txn(1, 10'h0D0 + AW'(i), 8'h30 + DW'(i), 0, 0, 0, 2'b00, 0, 8'h00, "b2b_wr");
    for (int i = 0; i < 3; i++)
      do_txn(0, 10'h0D0 + AW'(i), 8'h00, 0, 0, 0, 2'b00, 0, 8'h00, "b2b_rd");
    @(negedge clk);
  endtask

  task automatic test_spurious();
    int hits;
    cfg_spurious = 1;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) hits++;
    end
    vectors++;
    if (hits != 0) begin
      miscompares++;
      $display("FAIL spurious_idle: resp_valid high %0d cycles required 0", hits);
    end
    do_txn(0, 10'h0D1, 8'h00, 1, 0, 2, 2'b00, 0, 8'h00, "spur_rd");
    do_txn(1, 10'h0E0, 8'hC3, 1, 0, 2, 2'b00, 0, 8'h00, "spur_wr");
    cfg_spurious = 0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0] resp;
    int gap;
    for (int i = 0; i < 40; i++) begin
      we   = 1'($urandom_range(0, 1));
      a    = 10'h100 + AW'($urandom_range(0, 15));
      d    = DW'($urandom);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      do_txn(we, a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             resp, 0, 8'h00, "random");
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        vectors++;
        if (resp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL random_resp_once: resp_valid=%b required 0", resp_valid);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard, hits;
    cfg_ar_dly = 0; cfg_r_dly = 30;
    req_valid = 1; req_we = 0; req_addr = 10'h0D2;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 0;
    guard = 0;
    while (axi_rready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    vectors++;
    if (axi_rready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_reach: axi_rready=%b required 1", axi_rready);
    end
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    vectors++;
    if ({req_ready, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid} !== 7'h00) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %b required 0000000",
               {req_ready, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready, resp_valid});
    end
    reset = 0;
    model_rdata = '0;
    cfg_r_dly = 0;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ready: got %b required 1", req_ready);
    end
    hits = 0;
    repeat (4) begin
      if (resp_valid !== 1'b0) hits++;
      @(negedge clk);
    end
    vectors++;
    if (hits != 0) begin
      miscompares++;
      $display("FAIL reset_mid_no_resp: resp_valid high %0d cycles required 0", hits);
    end
    do_txn(0, 10'h0D2, 8'h00, 0, 0, 0, 2'b00, 0, 8'h00, "rd_after_reset");
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] v;
    reset = 1; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    last_awaddr = '0; last_araddr = '0; last_wdata = '0; last_wstrb = 0;
    for (int i = 0; i < 1024; i++) begin
      v = DW'($urandom);
      slv_mem[i] = v;
      exp_mem[i] = v;
    end
    test_reset();
    test_write_read();
    test_split_write();
    test_b_stall();
    test_read_err();
    test_back_to_back();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
